spi_slave: RTL and testbench

Single-clock SPI slave endpoint that consumes the serial bus produced by the team's `spi_master` (SCLK idle low, MOSI launched on SCLK falling edge, MISO sampled by the master on SCLK rising edge, 3-bit encoded slave select with idle code 3'b111). It oversamples SCLK/MOSI/SS in its own clock domain, deserialises one BITS-wide word per frame, and returns a pre-loaded response word on MISO. It sits directly downstream of the master, one instance per slave address.

---
 rtl/spi_pkg.sv | 13 +
 rtl/sync_2ff.sv | 26 ++
 rtl/spi_slave.sv | 156 +++++++++++++++
 tb/tb_spi_slave.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_slave shared types
// FSM state encoding and bus idle code
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [2:0] SS_IDLE = 3'b111;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for async pins
// Reset value is selectable per instance
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] meta;

  // two-stage capture of the asynchronous input
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta <= RST_VAL;
      o_q  <= RST_VAL;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/spi_slave.sv
// Oversampling SPI slave endpoint
// One frame per SS assertion, MSB first
module spi_slave
  import spi_pkg::*;
#(
  parameter int         BITS    = 20,
  parameter logic [2:0] ADDRESS = 3'd1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_sclk,
  input  logic            i_mosi,
  input  logic [2:0]      i_ss,
  output logic            o_miso,
  input  logic [BITS-1:0] i_tx_data,
  input  logic            i_tx_valid,
  output logic            o_tx_ready,
  output logic [BITS-1:0] o_rx_data,
  output logic            o_rx_valid,
  output logic            o_frame_err,
  output logic            o_busy
);

  localparam int CW = $clog2(BITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BITS);

  logic            sclk_s;
  logic            sclk_q;
  logic            mosi_s;
  logic [2:0]      ss_s;
  logic            sclk_rise;
  logic            sclk_fall;
  logic            selected;
  logic            start;
  logic            finish;
  state_t          state;
  logic [BITS-1:0] tx_sh;
  logic [BITS-1:0] rx_sh;
  logic [CW-1:0]   cnt;
  logic [BITS-1:0] hold_data;
  logic            hold_full;
  logic            tx_wr;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b0)
  ) u_sync_sclk (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_sclk),
    .o_q   (sclk_s)
  );

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b0)
  ) u_sync_mosi (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_mosi),
    .o_q   (mosi_s)
  );

  sync_2ff #(
    .WIDTH   (3),
    .RST_VAL (SS_IDLE)
  ) u_sync_ss (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_ss),
    .o_q   (ss_s)
  );

  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign selected  = (ss_s == ADDRESS);
  assign start     = (state == IDLE) & selected;
  assign finish    = (state == ACTIVE) & ~selected;
  assign tx_wr     = i_tx_valid & ~hold_full;

  assign o_tx_ready = ~hold_full;
  assign o_busy     = (state == ACTIVE);
  assign o_miso     = (state == ACTIVE) & tx_sh[BITS-1];

  // delayed synced SCLK for edge detection
  always_ff @(posedge i_clk) begin
    if (i_rst) sclk_q <= 1'b0;
    else       sclk_q <= sclk_s;
  end

  // frame sequencing: idle -> active -> done
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    if (selected) state <= ACTIVE;
        ACTIVE:  if (!selected) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // single-entry response holding register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else begin
      if (start) hold_full <= 1'b0;
      if (tx_wr) begin
        hold_full <= 1'b1;
        hold_data <= i_tx_data;
      end
    end
  end

  // shift registers and saturating rise counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_sh <= '0;
      rx_sh <= '0;
      cnt   <= '0;
    end else if (start) begin
      tx_sh <= hold_full ? hold_data : '0;
      rx_sh <= '0;
      cnt   <= '0;
    end else if (state == ACTIVE) begin
      if (sclk_rise) begin
        rx_sh <= {rx_sh[BITS-2:0], mosi_s};
        if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
      end
      if (sclk_fall) begin
        tx_sh <= {tx_sh[BITS-2:0], 1'b0};
      end
    end
  end

  // publish the received word when SS drops
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rx_data   <= '0;
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_rx_valid <= 1'b0;
      if (finish) begin
        o_rx_data   <= rx_sh;
        o_rx_valid  <= 1'b1;
        o_frame_err <= (cnt < CNT_MAX);
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave
// Random frames vs. a word-level model
module tb_spi_slave;
  import spi_pkg::*;

  localparam int         BITS = 20;
  localparam logic [2:0] ADDR = 3'd1;

  typedef struct {
    logic [BITS-1:0] d;
    logic            e;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            sclk;
  logic            mosi;
  logic [2:0]      ss;
  logic            miso;
  logic [BITS-1:0] tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [BITS-1:0] rx_data;
  logic            rx_valid;
  logic            frame_err;
  logic            busy;

  int tests = 0;
  int fails = 0;

  exp_t exp_q[$];

  logic            m_full = 1'b0;
  logic [BITS-1:0] m_data = '0;

  spi_slave #(
    .BITS    (BITS),
    .ADDRESS (ADDR)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_sclk      (sclk),
    .i_mosi      (mosi),
    .i_ss        (ss),
    .o_miso      (miso),
    .i_tx_data   (tx_data),
    .i_tx_valid  (tx_valid),
    .o_tx_ready  (tx_ready),
    .o_rx_data   (rx_data),
    .o_rx_valid  (rx_valid),
    .o_frame_err (frame_err),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: every rx_valid pulse must match a queued frame
  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rx_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rx_data", 64'(rx_data), 64'(e.d));
        chk("frame_err", 64'(frame_err), 64'(e.e));
      end
    end
  end

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("rx_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic wr(input logic [BITS-1:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    if (!m_full) begin
      m_full = 1'b1;
      m_data = d;
    end
    chk("tx_ready_full", 64'(tx_ready), 64'd0);
  endtask

  task automatic clock_bits(input logic [63:0] w,
                            input int n,
                            output logic [63:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      mosi = w[n-1-i];
      repeat (6) @(negedge clk);
      sclk = 1'b1;
      got  = {got[62:0], miso};
      repeat (6) @(negedge clk);
      sclk = 1'b0;
    end
    mosi = 1'b0;
  endtask

  function automatic logic [63:0] nmask(input int n);
    return (64'd1 << n) - 64'd1;
  endfunction

  task automatic frame(input logic [2:0] code,
                       input int n,
                       input logic [63:0] w_in);
    logic [63:0]     w;
    logic [63:0]     got;
    logic [63:0]     etx;
    logic [BITS-1:0] txw;
    logic            mine;
    exp_t            e;
    w    = w_in & nmask(n);
    mine = (code == ADDR);
    txw  = (mine && m_full) ? m_data : '0;
    if (mine) m_full = 1'b0;
    ss = code;
    repeat (8) @(negedge clk);
    chk("busy", 64'(busy), 64'(mine));
    chk("tx_ready", 64'(tx_ready), 64'(!m_full));
    clock_bits(w, n, got);
    repeat (6) @(negedge clk);
    if (mine) begin
      e.d = w[BITS-1:0];
      e.e = (n < BITS);
      exp_q.push_back(e);
    end
    ss = SS_IDLE;
    if (!mine)      etx = '0;
    else if (n >= BITS) etx = 64'(txw) << (n - BITS);
    else            etx = 64'(txw) >> (BITS - n);
    chk("miso_word", got, etx);
    repeat (8) @(negedge clk);
    wait_drain();
  endtask

  initial begin
    logic [63:0] got;
    rst      = 1'b1;
    sclk     = 1'b0;
    mosi     = 1'b0;
    ss       = SS_IDLE;
    tx_data  = '0;
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_miso", 64'(miso), 64'd0);
    chk("rst_rx_data", 64'(rx_data), 64'd0);
    chk("rst_rx_valid", 64'(rx_valid), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tx_ready", 64'(tx_ready), 64'd1);

    frame(ADDR, BITS, 64'hA5A5F);

    wr(20'h5C3A1);
    frame(ADDR, BITS, 64'h12345);

    wr(20'h0F0F0);
    frame(3'd2, BITS, 64'hFFFFF);
    frame(ADDR, 12, 64'hABC);
    frame(ADDR, 22, 64'h2DEAD5);

    ss = ADDR;
    repeat (8) @(negedge clk);
    clock_bits(64'hC3, 8, got);
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    m_full = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_after_rst", 64'(busy), 64'd1);
    exp_q.push_back('{d: 20'h15, e: 1'b1});
    clock_bits(64'h15, 5, got);
    repeat (6) @(negedge clk);
    ss = SS_IDLE;
    repeat (8) @(negedge clk);
    wait_drain();

    for (int k = 0; k < 10; k++) begin
      int          n;
      logic [2:0]  code;
      logic [63:0] w;
      if ($urandom_range(0, 1) == 1) begin
        wr(BITS'($urandom));
        if ($urandom_range(0, 1) == 1) wr(BITS'($urandom));
      end
      n    = ($urandom_range(0, 1) == 1) ? BITS
                                         : int'($urandom_range(1, 25));
      code = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 6))
                                         : ADDR;
      w    = {$urandom, $urandom};
      frame(code, n, w);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
